// File: rtl/adder3_arbiter.sv
// adder3_arbiter: four requesters share one three-operand adder through a
// round-robin arbiter. The grant is combinational; the sum is registered, so
// a result appears one cycle after its grant.
//
// Ports
//   i_clk    clock, all state on rising edge
//   i_rst    synchronous active-high reset
//   i_req    per-requester request (bit k = requester k ready)
//   i_A/B/C  operands, requester k on bits [k*N +: N]
//   i_stall  blocks new grants this cycle
//   o_gnt    one-hot combinational grant (zero when nothing granted)
//   o_valid  one-cycle pulse per granted operation
//   o_sum    (A+B+C) mod 2^N of the granted triple
//   o_carry  bits [N+1:N] of the full-precision sum
//   o_id     requester index that produced o_sum
//   o_busy   any request was pending in the previous cycle

// Per-requester adder: full-precision unsigned sum of one operand triple.
module adder3_lane #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N+1:0] sum
);
    assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
endmodule

module adder3_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*N-1:0] i_A,
    input  logic [NREQ*N-1:0] i_B,
    input  logic [NREQ*N-1:0] i_C,
    input  logic              i_stall,
    output logic [NREQ-1:0]   o_gnt,
    output logic              o_valid,
    output logic [N-1:0]      o_sum,
    output logic [1:0]        o_carry,
    output logic [1:0]        o_id,
    output logic              o_busy
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0][N+1:0] lane_sum;
    logic [IW-1:0]          p;
    logic [IW-1:0]          gid;
    logic [IW-1:0]          idx;
    logic                   any;

    // One adder per requester; the grant then just selects a finished sum.
    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        adder3_lane #(.N(N)) u_lane (
            .a   (i_A[k*N +: N]),
            .b   (i_B[k*N +: N]),
            .c   (i_C[k*N +: N]),
            .sum (lane_sum[k])
        );
    end

    // Round-robin search starting at p, wrapping through the top index to 0.
    always_comb begin
        any   = 1'b0;
        gid   = p;
        idx   = p;
        o_gnt = '0;
        if (!i_stall && !i_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = p + IW'(i);
                if (!any && i_req[idx]) begin
                    any = 1'b1;
                    gid = idx;
                end
            end
        end
        if (any) o_gnt[gid] = 1'b1;
    end

    // Result registers hold their value between grants; only o_valid pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p       <= '0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_carry <= '0;
            o_id    <= '0;
            o_busy  <= 1'b0;
        end else begin
            o_valid <= any;
            o_busy  <= |i_req;
            if (any) begin
                p       <= gid + IW'(1);
                o_sum   <= lane_sum[gid][N-1:0];
                o_carry <= lane_sum[gid][N+1:N];
                o_id    <= gid;
            end
        end
    end
endmodule

// File: tb/tb_adder3_arbiter.sv
// Self-checking bench for adder3_arbiter: a table of per-cycle stimulus with
// hand-computed grant/result expectations, then a fairness sequence.
module tb_adder3_arbiter;
    localparam int N = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [4*N-1:0]    a_bus, b_bus, c_bus;
    logic              stall;
    logic [3:0]        gnt;
    logic              valid;
    logic [N-1:0]      sum;
    logic [1:0]        carry;
    logic [1:0]        id;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder3_arbiter #(.N(N), .NREQ(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_A     (a_bus),
        .i_B     (b_bus),
        .i_C     (c_bus),
        .i_stall (stall),
        .o_gnt   (gnt),
        .o_valid (valid),
        .o_sum   (sum),
        .o_carry (carry),
        .o_id    (id),
        .o_busy  (busy)
    );

    // Operand modes:
    //   0: A=16k+1, B=256(k+1), C=k -> sums 0x101, 0x212, 0x323, 0x434
    //   1: all operands 0xFFFF      -> sum 0xFFFD, carry 2
    //   2: A=1, B=2, C=3            -> sum 6
    typedef struct {
        logic       rst;
        logic       stall;
        logic [3:0] req;
        int         mode;
        logic [3:0] gnt;
        logic       chk;
        logic       v;
        logic [15:0] sum;
        logic [1:0] carry;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic [3:0] rq, input int m,
                       input logic [3:0] g, input logic ck, input logic v,
                       input logic [15:0] sm, input logic [1:0] cy, input logic [1:0] i,
                       input logic b);
        vec_t e;
        e.rst = r; e.stall = s; e.req = rq; e.mode = m; e.gnt = g; e.chk = ck;
        e.v = v; e.sum = sm; e.carry = cy; e.id = i; e.busy = b;
        tbl.push_back(e);
    endtask

    task automatic set_ops(input int m);
        for (int k = 0; k < 4; k++) begin
            case (m)
                1:       begin a_bus[k*N +: N] = 16'hFFFF; b_bus[k*N +: N] = 16'hFFFF; c_bus[k*N +: N] = 16'hFFFF; end
                2:       begin a_bus[k*N +: N] = 16'd1;    b_bus[k*N +: N] = 16'd2;    c_bus[k*N +: N] = 16'd3;    end
                default: begin a_bus[k*N +: N] = 16'(16*k+1); b_bus[k*N +: N] = 16'(256*(k+1)); c_bus[k*N +: N] = 16'(k); end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    int gcount[4];

    initial begin
        rst = 1'b1; stall = 1'b0; req = 4'b0000; set_ops(0);

        //   rst stall req     mode gnt     chk v  sum      cy  id  busy
        add(1, 0, 4'b0000, 0, 4'b0000, 0, 0, 16'h0000, 0, 0, 0);
        add(1, 0, 4'b0000, 0, 4'b0000, 1, 0, 16'h0000, 0, 0, 0); // reset state
        add(0, 0, 4'b0010, 2, 4'b0010, 1, 0, 16'h0000, 0, 0, 0); // single request
        add(0, 0, 4'b0000, 2, 4'b0000, 1, 1, 16'd6,    0, 1, 1);
        add(0, 0, 4'b0000, 0, 4'b0000, 1, 0, 16'd6,    0, 1, 0); // held
        add(0, 0, 4'b1111, 0, 4'b0100, 1, 0, 16'd6,    0, 1, 0); // p=2
        add(0, 0, 4'b1111, 0, 4'b1000, 1, 1, 16'h0323, 0, 2, 1);
        add(0, 0, 4'b1111, 0, 4'b0001, 1, 1, 16'h0434, 0, 3, 1);
        add(0, 1, 4'b1111, 0, 4'b0000, 1, 1, 16'h0101, 0, 0, 1); // stall, in-flight emits
        add(0, 1, 4'b1111, 0, 4'b0000, 1, 0, 16'h0101, 0, 0, 1);
        add(0, 1, 4'b1111, 0, 4'b0000, 1, 0, 16'h0101, 0, 0, 1);
        add(0, 0, 4'b1111, 0, 4'b0010, 1, 0, 16'h0101, 0, 0, 1); // release -> p=1
        add(1, 0, 4'b1111, 0, 4'b0000, 1, 1, 16'h0212, 0, 1, 1); // reset mid-stream
        add(0, 0, 4'b1111, 0, 4'b0001, 1, 0, 16'h0000, 0, 0, 0); // restarts at 0
        add(0, 0, 4'b1111, 0, 4'b0010, 1, 1, 16'h0101, 0, 0, 1);
        add(0, 0, 4'b1111, 0, 4'b0100, 1, 1, 16'h0212, 0, 1, 1);
        add(0, 0, 4'b1111, 0, 4'b1000, 1, 1, 16'h0323, 0, 2, 1);
        add(0, 0, 4'b1111, 0, 4'b0001, 1, 1, 16'h0434, 0, 3, 1);
        add(0, 0, 4'b0010, 0, 4'b0010, 1, 1, 16'h0101, 0, 0, 1); // p=1 -> 2
        add(0, 0, 4'b0100, 0, 4'b0100, 1, 1, 16'h0212, 0, 1, 1); // p=2 -> 3
        add(0, 0, 4'b0101, 0, 4'b0001, 1, 1, 16'h0323, 0, 2, 1); // wrap 3 -> 0
        add(0, 0, 4'b0101, 0, 4'b0100, 1, 1, 16'h0101, 0, 0, 1);
        add(0, 0, 4'b0101, 0, 4'b0001, 1, 1, 16'h0323, 0, 2, 1);
        add(0, 0, 4'b0001, 1, 4'b0001, 1, 1, 16'h0101, 0, 0, 1); // overflow triple
        add(0, 0, 4'b0000, 1, 4'b0000, 1, 1, 16'hFFFD, 2, 0, 1);
        add(0, 0, 4'b0000, 1, 4'b0000, 1, 0, 16'hFFFD, 2, 0, 0);

        foreach (tbl[r]) begin
            @(negedge clk);
            rst = tbl[r].rst; stall = tbl[r].stall; req = tbl[r].req;
            set_ops(tbl[r].mode);
            #1;
            check($sformatf("gnt[%0d]", r), 32'(gnt), 32'(tbl[r].gnt));
            if (tbl[r].chk) begin
                check($sformatf("valid[%0d]", r), 32'(valid), 32'(tbl[r].v));
                check($sformatf("sum[%0d]", r),   32'(sum),   32'(tbl[r].sum));
                check($sformatf("carry[%0d]", r), 32'(carry), 32'(tbl[r].carry));
                check($sformatf("id[%0d]", r),    32'(id),    32'(tbl[r].id));
                check($sformatf("busy[%0d]", r),  32'(busy),  32'(tbl[r].busy));
            end
        end

        // Fairness: 8 cycles of all requesting -> each port granted twice,
        // exactly one grant per cycle, and o_valid high every cycle after the first.
        for (int k = 0; k < 4; k++) gcount[k] = 0;
        set_ops(0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req = 4'b1111;
            #1;
            check($sformatf("onehot[%0d]", c), 32'($countones(gnt)), 32'd1);
            if (c > 0) check($sformatf("b2b_valid[%0d]", c), 32'(valid), 32'd1);
            for (int k = 0; k < 4; k++) if (gnt[k]) gcount[k]++;
        end
        for (int k = 0; k < 4; k++) check($sformatf("fair_count[%0d]", k), 32'(gcount[k]), 32'd2);

        @(negedge clk);
        req = 4'b0000;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
